pixel_scanout: RTL and testbench
================================

# pixel_scanout

Receive end of the game's pixel-write interface (`x`, `y`, `colour`, `plot`). It stores writes into an internal 160x120x3-bit framebuffer. It scans the framebuffer out as 640x480@60 VGA timing, with each stored pixel replicated 4x4. It sits between the game datapath and the DAC pins and also gives the game a once-per-frame pacing tick.

## Interface
- `H_RES`, 160: framebuffer width in pixels.
- `V_RES`, 120: framebuffer height in pixels.
- `CLOCK_50`  in  1  50 MHz system clock; the only clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `x`  in  8  write column.
- `y`  in  7  write row.
- `colour`  in  3  write colour, {R,G,B}.
- `plot`  in  1  write strobe; sampled on every `CLOCK_50` edge.
- `busy`  out  1  high while the framebuffer clear sweep runs; writes are ignored while high.
- `frame_tick`  out  1  one-cycle pulse at the start of vertical blanking.
- `VGA_CLK`  out  1  25 MHz pixel clock.
- `VGA_HS`, `VGA_VS`  out  1  horizontal/vertical sync, active low.
- `VGA_BLANK_N`  out  1  low outside the visible area.
- `VGA_SYNC_N`  out  1  constant 0.
- `VGA_R`, `VGA_G`, `VGA_B`  out  10  colour channels.

## Operation
- **Write port**
  - `plot`=1 with `x`<160 and `y`<120 writes `colour` at address `y*160+x` on that edge.
  - Out-of-range coordinates are dropped silently.
  - Address arithmetic: 15 bits, `(y<<7)+(y<<5)+x`.
- **Pixel clock**
  - Toggle register `pe` alternates every `CLOCK_50` cycle.
  - `VGA_CLK = pe`.
  - Scan counters advance only on cycles where `pe`=1.
- **Horizontal counter** `hc` 0..799:
  - visible 0-639;
  - front porch 640-655;
  - sync 656-751;
  - back porch 752-799.
- **Vertical counter** `vc` 0..524:
  - advances when `hc` wraps 799→0;
  - visible 0-479;
  - front porch 480-489;
  - sync 490-491;
  - back porch 492-524;
  - wraps 524→0.
- **Read path**
  - Read address is `(vc>>2)*160 + (hc>>2)`.
  - Memory read is synchronous, 1 cycle.
  - Each colour bit expands to a 10-bit channel: 1→10'h3FF, 0→0.
  - Blank forces RGB to 0.
- **Read-during-write** to the same address returns the old data; the new value shows up on the next frame.
- **frame_tick** pulses for exactly one `CLOCK_50` cycle when `vc` becomes 480 with `hc`=0.
- **Reset values**:
  - `hc`=`vc`=0, `pe`=0;
  - `VGA_HS`=`VGA_VS`=1;
  - `VGA_BLANK_N`=0;
  - RGB=0;
  - `frame_tick`=0.
  - `busy` per Configuration.
  - Framebuffer contents are not touched by reset.
- **Reset mid-frame**: counters return to 0 immediately. Any in-flight write on the reset edge is lost.

## Timing
- **Write latency**: 1 cycle into memory. Earliest visibility on the display is the next scan of that pixel.
- **Scan pipeline**: counters → address (combinational) → memory (1 cycle) → output register (1 cycle).
  - HS, VS and BLANK_N are delayed through matching registers.
  - All VGA outputs are therefore aligned and lag the counters by 2 `CLOCK_50` cycles, i.e. one pixel period.
- **Frame length**: 800x525 pixel periods = 840000 `CLOCK_50` cycles.
  - `frame_tick` period is exactly 840000 cycles.
- **Writes** are accepted on every cycle regardless of `pe` or scan position. No backpressure except `busy`.

## Configuration
- **`FB_CLEAR_ON_RESET_EN` defined**:
  - After `resetn` deasserts, a 15-bit sweep counter writes 0 to addresses 0..19199, one per cycle.
  - `busy`=1 from reset through the cycle that writes address 19199; it reads 0 on the following cycle.
  - `busy` resets to 1.
  - External writes during the sweep are dropped.
  - Scan-out runs concurrently and displays partially cleared content.
- **Not defined**:
  - No sweep logic; `busy` is constant 0.
  - Framebuffer contents persist across reset (power-up contents are undefined/init file).

## Test plan
- **Reset**: assert `resetn`=0 mid-line, hold 3 cycles, release → `VGA_HS`=`VGA_VS`=1, `VGA_BLANK_N`=0 and RGB=0 while low. First `VGA_HS` low occurs 2*656+2 cycles after release.
- **Sync timing**: run 2 frames → HS low 192 cycles per 1600-cycle line. VS low for 2 lines starting line 490. `frame_tick` pulses exactly twice, 840000 cycles apart.
- **Write/scan**: write `colour`=3'b101 at (x=10, y=5), then scan → `VGA_R`=`VGA_B`=10'h3FF and `VGA_G`=0 for `hc` 40-43 on lines 20-23. All other visible pixels keep prior content.
- **Out-of-range**: `plot` with (x=160, y=0) and (x=0, y=120) → no address changes; a readback scan shows (0,0) and (159,119) unchanged.
- **Read-during-write**: write 3'b111 at (0,0) in the same cycle its read is issued on line 0 → old value output on that scan; 3'b111 on lines 1-3 and in later frames.
- **With `FB_CLEAR_ON_RESET_EN`**: preload 3'b111 everywhere, reset → `busy` high for 19200 cycles after release, a write during `busy` is ignored, the whole next frame is black.

Source files
------------

// File: rtl/pixel_scanout.sv
// rtl/pixel_scanout.sv - 160x120x3 framebuffer scanned out as 640x480@60 VGA, each pixel shown 4x4.
// Optional FB_CLEAR_ON_RESET_EN: sweep zeros through the framebuffer after reset while busy is high.
module pixel_scanout #(
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       busy,
  output logic       frame_tick,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);
  localparam int          FB_DEPTH = H_RES * V_RES;
  localparam logic [14:0] FB_LAST  = 15'(FB_DEPTH - 1);
  localparam logic [7:0]  X_LIM    = 8'(H_RES);
  localparam logic [6:0]  Y_LIM    = 7'(V_RES);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_LAST   = 10'd524;

  logic        pe;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        visible;
  logic        hs_raw;
  logic        vs_raw;
  logic [14:0] rrow;
  logic [14:0] raddr;
  logic [14:0] wrow;
  logic [14:0] waddr;
  logic        wr_ok;
  logic        mem_we;
  logic [14:0] mem_wa;
  logic [2:0]  mem_wd;
  logic [2:0]  rdata;
  logic        hs_d;
  logic        vs_d;
  logic        vis_d;
  logic [2:0]  fb [FB_DEPTH];

  assign VGA_CLK    = pe;
  assign VGA_SYNC_N = 1'b0;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pe         <= 1'b0;
      hc         <= '0;
      vc         <= '0;
      frame_tick <= 1'b0;
    end else begin
      pe         <= ~pe;
      frame_tick <= pe && (hc == H_LAST) && (vc == V_VIS - 10'd1);
      if (pe) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  // Blanking reads are parked at address 0 so the index never leaves the array.
  always_comb begin
    visible = (hc < H_VIS) && (vc < V_VIS);
    hs_raw  = !((hc >= H_SYNC_S) && (hc < H_SYNC_E));
    vs_raw  = !((vc >= V_SYNC_S) && (vc < V_SYNC_E));
    rrow    = {7'd0, vc[9:2]};
    raddr   = '0;
    if (visible) raddr = (rrow << 7) + (rrow << 5) + {7'd0, hc[9:2]};
    wrow    = {8'd0, y};
    waddr   = (wrow << 7) + (wrow << 5) + {7'd0, x};
    wr_ok   = resetn && plot && (x < X_LIM) && (y < Y_LIM) && !busy;
  end

`ifdef FB_CLEAR_ON_RESET_EN
  logic [14:0] clr_addr;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      busy     <= 1'b1;
      clr_addr <= '0;
    end else if (busy) begin
      if (clr_addr == FB_LAST) busy <= 1'b0;
      else clr_addr <= clr_addr + 15'd1;
    end
  end

  always_comb begin
    mem_we = (busy && resetn) || wr_ok;
    mem_wa = busy ? clr_addr : waddr;
    mem_wd = busy ? 3'b000 : colour;
  end
`else
  assign busy = 1'b0;

  always_comb begin
    mem_we = wr_ok;
    mem_wa = waddr;
    mem_wd = colour;
  end
`endif

  // Read and write share one block so a same-address collision returns the old data.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) fb[mem_wa] <= mem_wd;
    rdata <= fb[raddr];
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      vis_d       <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      hs_d        <= hs_raw;
      vs_d        <= vs_raw;
      vis_d       <= visible;
      VGA_HS      <= hs_d;
      VGA_VS      <= vs_d;
      VGA_BLANK_N <= vis_d;
      VGA_R       <= vis_d ? {10{rdata[2]}} : 10'd0;
      VGA_G       <= vis_d ? {10{rdata[1]}} : 10'd0;
      VGA_B       <= vis_d ? {10{rdata[0]}} : 10'd0;
    end
  end
endmodule

// File: tb/tb_pixel_scanout.sv
// tb/tb_pixel_scanout.sv - randomized bench for pixel_scanout with a time-based reference model.
module tb_pixel_scanout;
`ifdef FB_CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam int RUN = 46000;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy, frame_tick, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;

  int checks = 0;
  int errors = 0;

  pixel_scanout dut (
    .CLOCK_50(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .frame_tick(frame_tick), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #10 clk = ~clk;

  // Model: the display position is a pure function of edges since reset release;
  // memory contents lag by the pipeline, tracked with one pending write.
  logic [2:0] m_fb [0:19199];
  bit         m_known [0:19199];
  int         m_t = 0;
  bit         p_we = 1'b0;
  int         p_addr = 0;
  logic [2:0] p_col = '0;
  bit         e_clk, e_hs, e_vs, e_blank, e_tick, e_busy, e_valid;
  logic [2:0] e_col;

  always @(posedge clk) begin
    int n, h, v;
    if (!resetn) m_t = 0;
    else m_t++;
    e_clk = (m_t % 2) == 1;
    e_tick = (m_t > 0) && (m_t % 2 == 0) && (((m_t / 2) % 420000) == 384000);
    e_busy = CLR && (m_t < 19200);
    e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_col = 3'b000; e_valid = 1'b1;
    if (m_t >= 2) begin
      n = ((m_t - 2) / 2) % 420000;
      h = n % 800;
      v = n / 800;
      e_hs = !(h >= 656 && h < 752);
      e_vs = !(v >= 490 && v < 492);
      e_blank = (h < 640) && (v < 480);
      if (e_blank) begin
        e_col = m_fb[(v / 4) * 160 + h / 4];
        e_valid = m_known[(v / 4) * 160 + h / 4];
      end
    end
    if (p_we) begin
      m_fb[p_addr] = p_col;
      m_known[p_addr] = 1'b1;
    end
    p_we = 1'b0;
    if (resetn) begin
      if (CLR && m_t <= 19200) begin
        p_we = 1'b1; p_addr = m_t - 1; p_col = 3'b000;
      end else if (plot && x < 160 && y < 120) begin
        p_we = 1'b1; p_addr = int'(y) * 160 + int'(x); p_col = colour;
      end
    end
  end

  always @(posedge clk) begin
    logic [36:0] act, expv, msk;
    #5;
    act  = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_tick, busy, VGA_R, VGA_G, VGA_B};
    expv = {e_clk, e_hs, e_vs, e_blank, 1'b0, e_tick, e_busy,
            {10{e_col[2]}}, {10{e_col[1]}}, {10{e_col[0]}}};
    msk  = e_valid ? {37{1'b1}} : {7'h7F, 30'd0};
    checks++;
    if ((act & msk) !== (expv & msk)) begin
      errors++;
      $display("FAIL scan t=%0d actual=%h required=%h", m_t, act & msk, expv & msk);
    end
  end

  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  function automatic bit prot(input int px, input int py);
    return (px == 0 && py == 0) || (px == 0 && py == 1) || (py == 5 && px >= 9 && px <= 11) ||
           (px == 5 && py == 7);
  endfunction

  task automatic reset_hold();
    @(negedge clk);
    resetn = 1'b0;
    plot = 1'b1;
    repeat (3) begin
      @(posedge clk); #5;
      lit("rst_sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_N}, 32'd6);
      lit("rst_rgb", {2'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
      lit("rst_tick", {31'd0, frame_tick}, 32'd0);
    end
    @(negedge clk);
    plot = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    int hs_low;
    int rx, ry;
    resetn = 1'b0; plot = 1'b0; x = '0; y = '0; colour = '0;
    reset_hold();
`ifdef FB_CLEAR_ON_RESET_EN
    for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
    lit("busy_first_sweep_done", {31'd0, busy}, 32'd0);
`endif
    for (int yy = 0; yy < 12; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        x = 8'(xx); y = 7'(yy); plot = 1'b1;
        colour = 3'($urandom_range(7));
        if (xx == 0 && yy == 0) colour = 3'b010;
        else if (prot(xx, yy)) colour = 3'b000;
        @(negedge clk);
      end
    end
    plot = 1'b0;

    reset_hold();
    hs_low = 0;
    for (int k = 1; k <= RUN; k++) begin
      plot = 1'b0;
      if (k == 8) begin x = 8'd0; y = 7'd0; colour = 3'b111; plot = 1'b1; end
      else if (k == 200 || k == 19400) begin
        x = (k == 200) ? 8'd160 : 8'd165; y = (k == 200) ? 7'd0 : 7'd6;
        colour = 3'b111; plot = 1'b1;
      end
      else if (k == 201 || k == 19401) begin x = 8'd0; y = 7'd120; colour = 3'b111; plot = 1'b1; end
      else if (k == 19300) begin x = 8'd10; y = 7'd5; colour = 3'b101; plot = 1'b1; end
      else if ($urandom_range(7) == 0) begin
        rx = $urandom_range(199); ry = $urandom_range(127);
        if (!prot(rx, ry)) begin
          x = 8'(rx); y = 7'(ry); colour = 3'($urandom_range(7)); plot = 1'b1;
        end
      end
      @(posedge clk); #5;
      if (k >= 1602 && k <= 3201 && !VGA_HS) hs_low++;
      case (k)
        2:     lit("rdw_line0_first", {2'd0, VGA_R, VGA_G, VGA_B}, {2'd0, 10'h0, 10'h3FF, 10'h0});
        9:     lit("rdw_line0_last", {2'd0, VGA_R, VGA_G, VGA_B},
                   CLR ? 32'd0 : {2'd0, 10'h0, 10'h3FF, 10'h0});
        1313:  lit("hs_before_656", {31'd0, VGA_HS}, 32'd1);
        1314:  lit("hs_first_low", {31'd0, VGA_HS}, 32'd0);
        1602:  lit("rdw_line1", {2'd0, VGA_R, VGA_G, VGA_B},
                   CLR ? 32'd0 : {2'd0, 10'h3FF, 10'h3FF, 10'h3FF});
        3202:  lit("hs_low_per_line", hs_low, 32'd192);
        6402:  lit("oor_x160_alias", {2'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        32080: lit("pix_9_5", {2'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        33684: lit("pix_10_5", {2'd0, VGA_R, VGA_G, VGA_B}, {2'd0, 10'h3FF, 10'h0, 10'h3FF});
        36890: lit("pix_11_5", {2'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        44842: lit("oor_x165_alias", {2'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        19199: lit("busy_last_sweep", {31'd0, busy}, {31'd0, CLR});
        19200: lit("busy_after_sweep", {31'd0, busy}, 32'd0);
        default: ;
      endcase
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
